ascon_enc_sequencer: RTL and testbench

//  Host-facing controller for the masked serial Ascon encryption core.
//  - Accepts a parallel job (key, nonce, AD, PT) over a valid/ready handshake.
//  - Shifts the job bit-serially into the core, supplying fresh mask/random bits from an internal LFSR.
//  - Pulses encryption start, waits for ready, then deserialises CT and tag.
//  - Returns CT and tag on a valid/ready output handshake.
//  - Sits between the system bus wrapper and the Ascon core; one job in flight at a time.

---
 rtl/ascon_enc_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_ascon_enc_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_enc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : ascon_enc_sequencer
//  Brief   : Host-side job sequencer for the masked bit-serial Ascon core.
//            Serialises key/nonce/AD/PT with LFSR randomness, starts the
//            core, then deserialises CT and tag back to the host.
//  Revision: 1.0 - initial release
// ============================================================================
module ascon_enc_sequencer #(
    parameter int K        = 128,
    parameter int Y        = 40,
    parameter int L        = 40,
    parameter int START_CY = 3,
    parameter int DRAIN_CY = 4,
    parameter int TIMEOUT  = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [K-1:0] key,
    input  logic [127:0] nonce,
    input  logic [L-1:0] ad,
    input  logic [Y-1:0] pt,
    input  logic [31:0]  seed,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [Y-1:0] ct,
    output logic [127:0] tag,
    output logic         err,
    output logic [2:0]   key_si,
    output logic [2:0]   nonce_si,
    output logic [2:0]   ad_si,
    output logic [2:0]   pt_si,
    output logic [6:0]   r_64_si,
    output logic         r_128_si,
    output logic         r_pt_si,
    output logic         enc_start,
    input  logic         ct_so,
    input  logic         tag_so,
    input  logic         enc_ready
);

    localparam int MAX   = (K > Y) ? ((K > L) ? K : L) : ((Y > L) ? Y : L);
    localparam int RDLEN = (MAX > 128) ? MAX : 128;
    localparam int CW    = $clog2(RDLEN + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] MAX_LAST   = CW'(MAX - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_CY - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CY - 1);
    localparam logic [CW-1:0] RD_LAST    = CW'(RDLEN - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [31:0]   LFSR_TAPS  = 32'h8020_0003;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_READ  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [TW-1:0] wcnt_q,  wcnt_d;
    logic [31:0]   lfsr_q,  lfsr_d;
    logic [K-1:0]  key_q,   key_d;
    logic [127:0]  nonce_q, nonce_d;
    logic [L-1:0]  ad_q,    ad_d;
    logic [Y-1:0]  pt_q,    pt_d;
    logic [Y-1:0]  ct_q,    ct_d;
    logic [127:0]  tag_q,   tag_d;
    logic          err_q,   err_d;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        lfsr_next = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            lfsr_q  <= 32'h1;
            key_q   <= '0;
            nonce_q <= '0;
            ad_q    <= '0;
            pt_q    <= '0;
            ct_q    <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            lfsr_q  <= lfsr_d;
            key_q   <= key_d;
            nonce_q <= nonce_d;
            ad_q    <= ad_d;
            pt_q    <= pt_d;
            ct_q    <= ct_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        lfsr_d  = lfsr_q;
        key_d   = key_q;
        nonce_d = nonce_q;
        ad_d    = ad_q;
        pt_d    = pt_q;
        ct_d    = ct_q;
        tag_d   = tag_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    key_d   = key;
                    nonce_d = nonce;
                    ad_d    = ad;
                    pt_d    = pt;
                    lfsr_d  = (seed == 32'd0) ? 32'h1 : seed;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Operands shift MSB-first; zeros fill once a short operand runs out
                key_d   = {key_q[K-2:0], 1'b0};
                nonce_d = {nonce_q[126:0], 1'b0};
                ad_d    = {ad_q[L-2:0], 1'b0};
                pt_d    = {pt_q[Y-2:0], 1'b0};
                lfsr_d  = lfsr_next(lfsr_q);
                if (cnt_q == MAX_LAST) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d   = '0;
                    wcnt_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (enc_ready) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else if (wcnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    ct_d    = '0;
                    tag_d   = '0;
                    state_d = S_DONE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READ: begin
                for (int i = 0; i < Y; i++) begin
                    if (cnt_q == CW'(i)) ct_d[i] = ct_so;
                end
                for (int i = 0; i < 128; i++) begin
                    if (cnt_q == CW'(i)) tag_d[i] = tag_so;
                end
                if (cnt_q == RD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        job_ready = (state_q == S_IDLE);
        res_valid = (state_q == S_DONE);
        enc_start = (state_q == S_START);
        key_si    = 3'b000;
        nonce_si  = 3'b000;
        ad_si     = 3'b000;
        pt_si     = 3'b000;
        r_64_si   = 7'd0;
        r_pt_si   = 1'b0;
        r_128_si  = 1'b0;
        if (state_q == S_LOAD) begin
            key_si   = {lfsr_q[7:6], key_q[K-1]};
            ad_si    = {lfsr_q[5:4], ad_q[L-1]};
            pt_si    = {lfsr_q[3:2], pt_q[Y-1]};
            nonce_si = {lfsr_q[1:0], nonce_q[127]};
            r_64_si  = lfsr_q[14:8];
            r_pt_si  = lfsr_q[15];
            r_128_si = lfsr_q[16];
        end
    end

    assign ct  = ct_q;
    assign tag = tag_q;
    assign err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ascon_enc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_ascon_enc_sequencer
//  Brief   : Directed vector bench with a behavioural stub of the serial core.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_ascon_enc_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         job_valid, job_ready;
    logic [127:0] key, nonce;
    logic [39:0]  ad, pt;
    logic [31:0]  seed;
    logic         res_valid, res_ready;
    logic [39:0]  ct;
    logic [127:0] tag;
    logic         err;
    logic [2:0]   key_si, nonce_si, ad_si, pt_si;
    logic [6:0]   r_64_si;
    logic         r_128_si, r_pt_si, enc_start;
    logic         ct_so, tag_so, enc_ready;

    always #5 clk = ~clk;

    ascon_enc_sequencer dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .key(key), .nonce(nonce), .ad(ad), .pt(pt), .seed(seed),
        .res_valid(res_valid), .res_ready(res_ready), .ct(ct), .tag(tag), .err(err),
        .key_si(key_si), .nonce_si(nonce_si), .ad_si(ad_si), .pt_si(pt_si),
        .r_64_si(r_64_si), .r_128_si(r_128_si), .r_pt_si(r_pt_si),
        .enc_start(enc_start), .ct_so(ct_so), .tag_so(tag_so), .enc_ready(enc_ready)
    );

    typedef struct {
        logic [127:0] key;
        logic [127:0] nonce;
        logic [39:0]  ad;
        logic [39:0]  pt;
        logic [31:0]  seed;
        logic [39:0]  ct_pat;
        logic [127:0] tag_pat;
        int           delay;     // WAIT cycles until enc_ready is sampled; -1 = never
        logic [39:0]  exp_ct;
        logic [127:0] exp_tag;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    vec_t        vecs[5];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          accepts  = 0;
    int          t0       = 0;
    int          rv_first = -1;
    int          acc0;
    logic [16:0] obs_rnd[3];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (!rst && job_valid && job_ready) accepts <= accepts + 1;

    task automatic check_vec(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_reset(input string nm);
        check_vec(nm, 256'({job_ready, res_valid, err, enc_start, ct, tag, key_si, nonce_si,
                            ad_si, pt_si, r_64_si, r_128_si, r_pt_si}),
                  256'({1'b1, 192'b0}));
    endtask

    function automatic logic [31:0] lfsr_model(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (res_valid && rv_first < 0) rv_first = cyc - t0;
    endtask

    task automatic run_job(input vec_t v, input bit hold, input int abort_at);
        logic [127:0] ck, cn;
        logic [39:0]  ca, cp;
        logic [31:0]  m;
        logic [16:0]  obs;
        int           bad_rnd, bad_pad, n_st;
        ck = '0; cn = '0; ca = '0; cp = '0;
        bad_rnd = 0; bad_pad = 0; n_st = 0;
        m = (v.seed == 32'd0) ? 32'h1 : v.seed;
        @(negedge clk);
        key = v.key; nonce = v.nonce; ad = v.ad; pt = v.pt; seed = v.seed;
        job_valid = 1'b1;
        check_vec("job_ready_idle", 256'(job_ready), 256'(1));
        t0 = cyc;
        rv_first = -1;
        tick();
        if (!hold) job_valid = 1'b0;
        check_vec("err_clear_on_accept", 256'(err), 256'(0));
        check_vec("job_ready_busy", 256'(job_ready), 256'(0));
        for (int i = 0; i < 128; i++) begin
            ck[127-i] = key_si[0];
            cn[127-i] = nonce_si[0];
            if (i < 40) begin
                ca[39-i] = ad_si[0];
                cp[39-i] = pt_si[0];
            end else if (ad_si[0] || pt_si[0]) begin
                bad_pad++;
            end
            obs = {r_128_si, r_pt_si, r_64_si, key_si[2:1], ad_si[2:1], pt_si[2:1], nonce_si[2:1]};
            if (i < 3) obs_rnd[i] = obs;
            if (obs !== m[16:0]) bad_rnd++;
            m = lfsr_model(m);
            tick();
        end
        check_vec("lane_key", 256'(ck), 256'(v.key));
        check_vec("lane_nonce", 256'(cn), 256'(v.nonce));
        check_vec("lane_ad", 256'(ca), 256'(v.ad));
        check_vec("lane_pt", 256'(cp), 256'(v.pt));
        check_vec("lane_pad_zero", 256'(bad_pad), 256'(0));
        check_vec("lfsr_seq", 256'(bad_rnd), 256'(0));
        check_vec("lanes_idle_after_load",
                  256'({key_si, nonce_si, ad_si, pt_si, r_64_si, r_128_si, r_pt_si}), 256'(0));
        for (int j = 0; j < 3; j++) begin
            if (enc_start) n_st++;
            tick();
        end
        check_vec("enc_start_width", 256'({n_st, 31'd0, enc_start}), 256'({32'd3, 32'd0}));
        if (v.delay > 0) begin
            repeat (v.delay - 1) tick();
            enc_ready = 1'b1;
            tick();
            enc_ready = 1'b0;
            repeat (4) tick();
            for (int i = 0; i < 128; i++) begin
                if (i == abort_at) begin
                    rst = 1'b1;
                    #1;
                    check_reset("rst_mid_read");
                    @(negedge clk);
                    rst = 1'b0;
                    ct_so = 1'b0;
                    tag_so = 1'b0;
                    return;
                end
                if (i < 40) ct_so = v.ct_pat[i];
                else        ct_so = 1'($urandom);
                tag_so = v.tag_pat[i];
                tick();
            end
            ct_so = 1'b0;
            tag_so = 1'b0;
        end
        for (int w = 0; w < 5000 && !res_valid; w++) tick();
        check_vec("res_valid_seen", 256'(res_valid), 256'(1));
        check_vec("latency", 256'(rv_first), 256'(v.exp_lat));
        check_vec("ct", 256'(ct), 256'(v.exp_ct));
        check_vec("tag", 256'(tag), 256'(v.exp_tag));
        check_vec("err", 256'(err), 256'(v.exp_err));
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_vec("res_handshake", 256'({res_valid, job_ready}), 256'(2'b01));
    endtask

    initial begin
        rst = 1'b1; job_valid = 1'b0; res_ready = 1'b0; enc_ready = 1'b0;
        ct_so = 1'b0; tag_so = 1'b0; key = '0; nonce = '0; ad = '0; pt = '0; seed = '0;

        vecs[0] = '{128'h2db083053e848cefa30007336c47a5a1, 128'h3f3607dbce3503ba84f5843d623de056,
                    40'h4153434f4e, 40'h6173636f6e, 32'h1, 40'h6173636f6e,
                    128'h0123456789abcdef0123456789abcdef, 10,
                    40'h6173636f6e, 128'h0123456789abcdef0123456789abcdef, 1'b0, 274};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h0f0e0d0c0b0a09080706050403020100,
                    40'h0000000001, 40'h8000000000, 32'h0, 40'ha5a5a5a5a5,
                    128'hffffffff00000000ffffffff00000000, 1,
                    40'ha5a5a5a5a5, 128'hffffffff00000000ffffffff00000000, 1'b0, 265};
        vecs[2] = '{128'hffffffffffffffffffffffffffffffff, 128'h0, 40'hffffffffff, 40'h0123456789,
                    32'hdeadbeef, 40'h8000000001, 128'h80000000000000000000000000000001, 3,
                    40'h8000000001, 128'h80000000000000000000000000000001, 1'b0, 267};
        vecs[3] = '{128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a, 128'h1, 40'h1, 40'h2,
                    32'h12345678, 40'hffffffffff, 128'h1, -1,
                    40'h0, 128'h0, 1'b1, 4228};
        vecs[4] = '{128'hc3c3c3c3c3c3c3c3c3c3c3c3c3c3c3c3, 128'h8badf00d8badf00d8badf00d8badf00d,
                    40'h1234567890, 40'hfedcba0987, 32'hffffffff, 40'h1122334455,
                    128'h00112233445566778899aabbccddeeff, 7,
                    40'h1122334455, 128'h00112233445566778899aabbccddeeff, 1'b0, 271};

        repeat (3) @(negedge clk);
        check_reset("reset_in_rst");
        rst = 1'b0;
        @(negedge clk);
        check_reset("reset_after_release");

        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_vec("res_ready_in_idle", 256'({job_ready, res_valid}), 256'(2'b10));
        res_ready = 1'b0;

        for (int t = 0; t < 5; t++) begin
            run_job(vecs[t], 1'b0, -1);
            if (t == 1) check_vec("seed0_first3", 256'({obs_rnd[0], obs_rnd[1], obs_rnd[2]}),
                                  256'({17'h00001, 17'h00003, 17'h00002}));
            if (t == 2) check_vec("seed_deadbeef_first3", 256'({obs_rnd[0], obs_rnd[1], obs_rnd[2]}),
                                  256'({17'h1beef, 17'h0df74, 17'h16fba}));
            handshake();
        end

        // Reset in the middle of LOAD, then a clean job
        @(negedge clk);
        key = vecs[4].key; nonce = vecs[4].nonce; ad = vecs[4].ad; pt = vecs[4].pt;
        seed = vecs[4].seed; job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("rst_mid_load");
        @(negedge clk);
        rst = 1'b0;
        run_job(vecs[0], 1'b0, -1);
        handshake();

        // Reset in the middle of READ, then a clean job
        run_job(vecs[2], 1'b0, 60);
        run_job(vecs[4], 1'b0, -1);
        handshake();

        // job_valid held high across a whole job, result held back for 20 cycles
        acc0 = accepts;
        run_job(vecs[1], 1'b1, -1);
        check_vec("single_accept", 256'(accepts - acc0), 256'(1));
        repeat (20) tick();
        check_vec("hold_res_valid", 256'(res_valid), 256'(1));
        check_vec("hold_ct", 256'(ct), 256'(vecs[1].exp_ct));
        check_vec("hold_tag", 256'(tag), 256'(vecs[1].exp_tag));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_vec("idle_after_release", 256'({job_ready, accepts - acc0}), 256'({1'b1, 32'd1}));
        @(negedge clk);
        check_vec("second_accept", 256'({job_ready, accepts - acc0}), 256'({1'b0, 32'd2}));
        job_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
